// File: rtl/uart_upg_loader.sv
`default_nettype none
// ============================================================================
// uart_upg_loader : UART image loader driving the IMem/DMem upgrade ports
// Revision 1.0
// ============================================================================
module uart_upg_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        upg_clk_i,
    input  logic        upg_rstn_i,
    input  logic        rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] C_TMO_M1  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [15:0]      C_MAX_N   = 16'd16384;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    state_t           state_q, state_d;
    logic             target_q, target_d;
    logic [7:0]       cnt_lo_q, cnt_lo_d;
    logic [14:0]      remaining_q, remaining_d;
    logic [13:0]      addr_q, addr_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      word_q, word_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             wen_q, wen_d;
    logic [14:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             w_start_det;
    logic             w_timed;
    logic             w_tmo_expire;
    logic [15:0]      w_count;

    always_comb begin
        rx_meta_d    = rx_i;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        w_start_det  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d  = RX_START;
                    clk_cnt_d   = '0;
                    w_start_det = 1'b1;
                end
            end
            RX_START: begin
                // Mid-start resample: a line that is high again was only a glitch
                if (clk_cnt_q == C_HALF_M1) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == C_BIT_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (clk_cnt_q == C_BIT_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign w_timed      = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) || (state_q == ST_DATA);
    assign w_tmo_expire = w_timed && (rx_state_q == RX_IDLE) && !w_start_det &&
                          !byte_valid_q && (tmo_q == C_TMO_M1);
    assign w_count      = {byte_q, cnt_lo_q};

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cnt_lo_d    = cnt_lo_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        wen_d       = 1'b0;
        adr_d       = adr_q;
        dat_d       = dat_q;

        if (!w_timed || w_start_det || byte_valid_q) begin
            tmo_d = '0;
        end else if (rx_state_q == RX_IDLE) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            ST_HDR: begin
                if (byte_valid_q) begin
                    if (byte_q[7:1] == 7'd0) begin
                        target_d = byte_q[0];
                        state_d  = ST_CNT_LO;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_CNT_LO: begin
                if (byte_valid_q) begin
                    cnt_lo_d = byte_q;
                    state_d  = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (byte_valid_q) begin
                    if (w_count == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (w_count > C_MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        remaining_d = w_count[14:0];
                        addr_d      = '0;
                        byte_idx_d  = '0;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Shifting down from the top lands byte k in bits [8k+7:8k] after four bytes
                if (byte_valid_q) begin
                    word_d = {byte_q, word_q[31:8]};
                    if (byte_idx_q == 2'd3) begin
                        wen_d   = 1'b1;
                        adr_d   = {target_q, addr_q};
                        dat_d   = {byte_q, word_q[31:8]};
                        state_d = ST_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            ST_WRITE: begin
                addr_d      = addr_q + 14'd1;
                remaining_d = remaining_q - 15'd1;
                byte_idx_d  = '0;
                state_d     = (remaining_q == 15'd1) ? ST_DONE : ST_DATA;
            end
            default: begin
            end
        endcase

        if (w_tmo_expire || (frame_err_q && (state_q != ST_DONE) && (state_q != ST_ERR))) begin
            state_d = ST_ERR;
            wen_d   = 1'b0;
            adr_d   = adr_q;
            dat_d   = dat_q;
        end

        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge upg_clk_i) begin
        if (!upg_rstn_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= ST_HDR;
            target_q     <= 1'b0;
            cnt_lo_q     <= '0;
            remaining_q  <= '0;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            tmo_q        <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            target_q     <= target_d;
            cnt_lo_q     <= cnt_lo_d;
            remaining_q  <= remaining_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            tmo_q        <= tmo_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_upg_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_upg_loader : randomized self-checking bench for uart_upg_loader
// Revision 1.0
// ============================================================================
module tb_uart_upg_loader;

    localparam int CPB = 8;
    localparam int TOB = 4;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        rx   = 1'b1;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        upg_err_o;

    always #5 clk = ~clk;

    uart_upg_loader #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .upg_clk_i  (clk),
        .upg_rstn_i (rstn),
        .rx_i       (rx),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .upg_err_o  (upg_err_o)
    );

    typedef struct packed {
        logic [14:0] adr;
        logic [31:0] dat;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         fe_idx;
    logic       exp_done;
    logic       exp_err;
    int         cyc = 0;
    int         last_wen_cyc = -1;
    int         done_rise_cyc = -1;
    logic       done_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (upg_wen_o) begin
            obs_q.push_back({upg_adr_o, upg_dat_o});
            last_wen_cyc = cyc;
        end
        if (upg_done_o && !done_prev) done_rise_cyc = cyc;
        done_prev = upg_done_o;
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        obs_q.delete();
        last_wen_cyc  = -1;
        done_rise_cyc = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Sends tx_q up to and including the framing-error byte (if any)
    task automatic play(input int max_gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (fe_idx >= 0 && i > fe_idx) break;
            send_byte(tx_q[i], (i != fe_idx));
            repeat ($urandom_range(1, max_gap)) @(negedge clk);
        end
    endtask

    // Reference: derive the write list and final flags directly from the byte image
    task automatic build_expect();
        int len;
        int n;
        int full;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        len = (fe_idx >= 0) ? fe_idx : tx_q.size();
        if (fe_idx == 0) begin
            exp_err = 1'b1;
            return;
        end
        if (len == 0) return;
        if (tx_q[0] > 8'd1 || len < 3) begin
            exp_err = 1'b1;
            return;
        end
        n = int'(tx_q[1]) + 256 * int'(tx_q[2]);
        if (n == 0) begin
            exp_done = 1'b1;
            return;
        end
        if (n > 16384) begin
            exp_err = 1'b1;
            return;
        end
        full = (len - 3) / 4;
        if (full > n) full = n;
        for (int w = 0; w < full; w++) begin
            wr_t e;
            e.adr = 15'(int'(tx_q[0]) * 16384 + w);
            e.dat = 32'(tx_q[3 + 4 * w]) + (32'(tx_q[4 + 4 * w]) << 8) +
                    (32'(tx_q[5 + 4 * w]) << 16) + (32'(tx_q[6 + 4 * w]) << 24);
            exp_q.push_back(e);
        end
        if (full == n) exp_done = 1'b1;
        else           exp_err  = 1'b1;
    endtask

    task automatic run_check(input string tag);
        repeat (80) @(negedge clk);
        build_expect();
        check_eq({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("%s_adr%0d", tag, i), 64'(obs_q[i].adr), 64'(exp_q[i].adr));
            check_eq($sformatf("%s_dat%0d", tag, i), 64'(obs_q[i].dat), 64'(exp_q[i].dat));
        end
        check_eq({tag, "_done"}, 64'(upg_done_o), 64'(exp_done));
        check_eq({tag, "_err"},  64'(upg_err_o),  64'(exp_err));
    endtask

    task automatic load(input logic [7:0] bytes[$]);
        tx_q   = bytes;
        fe_idx = -1;
    endtask

    initial begin
        int bad;
        int kind;
        int n;

        // Reset and idle line
        do_reset();
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (upg_wen_o || upg_done_o || upg_err_o || (upg_adr_o != 0) || (upg_dat_o != 0)) bad++;
        end
        check_eq("idle_quiet", 64'(bad), 64'd0);
        check_eq("idle_done", 64'(upg_done_o), 64'd0);

        // Two-word DMem image and done latency
        do_reset();
        load('{8'h01, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12});
        play(12);
        run_check("dmem2");
        check_eq("done_latency", 64'(done_rise_cyc), 64'(last_wen_cyc + 1));

        // Zero-length image, trailing bytes ignored
        do_reset();
        load('{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        play(12);
        run_check("zero_len");

        // Bad target byte, later stream locked out
        do_reset();
        load('{8'h07, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        play(12);
        run_check("bad_tgt");

        // Timeout mid-word
        do_reset();
        load('{8'h00, 8'h01, 8'h00, 8'h11, 8'h22});
        play(4);
        repeat (6) @(negedge clk);
        check_eq("tmo_early", 64'(upg_err_o), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("tmo_late", 64'(upg_err_o), 64'd1);
        run_check("tmo");

        // Framing error on count low byte
        do_reset();
        load('{8'h00, 8'h34, 8'h12});
        fe_idx = 1;
        play(12);
        run_check("frame");

        // Count just above the address space
        do_reset();
        load('{8'h00, 8'h01, 8'h40});
        play(12);
        run_check("n_over");

        // Short low glitch on idle line, then a normal one-word load
        do_reset();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("glitch_err", 64'(upg_err_o), 64'd0);
        check_eq("glitch_nwr", 64'(obs_q.size()), 64'd0);
        load('{8'h01, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h8B});
        play(12);
        run_check("post_glitch");

        // Reset in the middle of a word
        do_reset();
        load('{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33});
        play(6);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        load('{8'h00, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
        play(12);
        run_check("mid_rst");

        // Randomized images, including bad targets, truncation, extras and framing errors
        for (int it = 0; it < 10; it++) begin
            do_reset();
            tx_q.delete();
            fe_idx = -1;
            kind = int'($urandom_range(0, 7));
            n    = int'($urandom_range(0, 4));
            tx_q.push_back((kind == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
            tx_q.push_back(8'(n));
            tx_q.push_back(8'h00);
            for (int k = 0; k < 4 * n; k++) tx_q.push_back(8'($urandom));
            if (kind == 1) begin
                repeat ($urandom_range(1, 3)) void'(tx_q.pop_back());
            end else if (kind == 2) begin
                tx_q.push_back(8'($urandom));
                tx_q.push_back(8'($urandom));
            end else if (kind == 3) begin
                fe_idx = int'($urandom_range(0, tx_q.size() - 1));
            end
            play(12);
            run_check($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_upg_loader.md
Name: uart_upg_loader

Overview:
- Upstream feeder of the data and instruction memories' upgrade ports.
- Receives a UART byte stream from the host PC and validates framing.
- Assembles little-endian 32-bit words and issues one-cycle write strobes with an incrementing word address.
- Raises a sticky done flag when the image is complete; this flag hands the memories back to CPU mode.

Parameters:
- CLKS_PER_BIT, 87, upg_clk_i cycles per UART bit (10 MHz / 115200); must be >= 4.
- TIMEOUT_BITS, 64, bit-times of line silence tolerated between bytes once a transfer has started.

Ports:
- upg_clk_i  in  1  single clock for the whole block.
- upg_rstn_i  in  1  synchronous, active-low reset.
- rx_i  in  1  raw UART line, asynchronous, idle high.
- upg_wen_o  out  1  one-cycle write strobe per assembled word.
- upg_adr_o  out  15  bit 14: target (0 = IMem, 1 = DMem); bits 13:0: word address.
- upg_dat_o  out  32  assembled word, valid while upg_wen_o = 1.
- upg_done_o  out  1  sticky; image fully written.
- upg_err_o  out  1  sticky; protocol, framing or timeout error.

Behaviour:
- Reset (upg_rstn_i = 0 at a clock edge): all outputs 0; FSM to HDR; RX to idle; counters cleared. Reset mid-transfer aborts silently; no partial word is written.
- rx_i passes through a 2-flop synchronizer before use.
- RX start detection: falling edge on the synchronized line, then resample at CLKS_PER_BIT/2.
  - If still low, it is a valid start; otherwise return to idle (glitch rejected).
- RX data: 8 data bits, LSB first, sampled at bit centres every CLKS_PER_BIT cycles.
- RX stop bit:
  - Stop = 1: emit byte_valid for one cycle.
  - Stop = 0: framing error, which forces FSM to ERR.
- Protocol byte stream: target byte (0x00 = IMem, 0x01 = DMem), count low byte, count high byte, then N words of 4 bytes each, LSB first.
- FSM states:
  - HDR: target byte 0x00/0x01 goes to CNT_LO; any other value goes to ERR.
  - CNT_LO: latches the count low byte, then CNT_HI.
  - CNT_HI: latches the count high byte.
    - N = 0 goes directly to DONE.
    - N > 16384 goes to ERR.
    - Otherwise go to DATA with byte index 0 and word address 0.
  - DATA: byte k (0..3) is placed in word bits [8k+7:8k]. On k = 3, go to WRITE.
  - WRITE: single cycle.
    - upg_wen_o = 1; upg_adr_o = {target, addr}; upg_dat_o = word.
    - Then addr += 1 and remaining -= 1.
    - remaining reaching 0 goes to DONE; otherwise back to DATA.
  - DONE: upg_done_o = 1, held until reset. Further rx bytes are ignored (RX still runs; no writes).
  - ERR: upg_err_o = 1, held until reset. upg_done_o stays 0 and no writes occur.
- Latency: upg_wen_o rises exactly 1 cycle after the byte_valid of the 4th byte of a word. upg_done_o rises the cycle after the final WRITE.
- Timeout: in CNT_LO, CNT_HI or DATA, TIMEOUT_BITS*CLKS_PER_BIT cycles with RX idle and no byte_valid forces ERR. The counter clears on every start-bit detection. HDR never times out.
- Address never wraps: the limit N <= 16384 keeps addr in 0..16383.
- upg_dat_o and upg_adr_o hold their last values outside WRITE; consumers qualify on upg_wen_o only.

Test Plan (bench uses CLKS_PER_BIT = 8, TIMEOUT_BITS = 4):
- Reset then idle line: all outputs 0 for 1000 cycles; upg_done_o = 0.
- Send 01 02 00 EF BE AD DE 78 56 34 12:
  - two strobes: adr 0x4000 / dat 0xDEADBEEF, then adr 0x4001 / dat 0x12345678;
  - upg_done_o = 1 the cycle after the 2nd strobe.
- Send 00 00 00: no strobes; upg_done_o = 1; then send 00 01 00 AA BB CC DD: still no strobes.
- Send 07: upg_err_o = 1, upg_done_o = 0; a later valid stream produces no strobes until reset.
- Send 00 01 00 11 22, then hold the line idle: upg_err_o = 1 after 32 idle cycles; no strobe.
- Framing and glitch checks:
  - Drive a stop bit of 0 on the count low byte: upg_err_o = 1.
  - A 2-cycle low glitch on an idle line: no byte is decoded.
- Mid-word reset: send 00 01 00 11 22 33, pulse upg_rstn_i low 1 cycle, then send 00 01 00 44 33 22 11. Exactly one strobe: adr 0x0000, dat 0x11223344.
